// File: rtl/axi_slice_isolate_if.sv
// AXI4 bus bundle shared by the upstream and downstream ports of axi_slice_isolate.
// Master drives requests (AW, W, AR) and response readies; Slave is the mirror image.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 6
);
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_region;
    logic [3:0]                aw_qos;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_region;
    logic [3:0]                ar_qos;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_region, aw_qos, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_region, ar_qos, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_region, aw_qos, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_region, ar_qos, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi_slice_isolate.sv
// AXI register slice with per-channel FIFOs, outstanding-transaction limiting and
// an isolation state machine that stops new AW/AR and drains in-flight traffic.
module axi_slice_isolate_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= (wptr == LAST_PTR) ? '0 : wptr + 1'b1;
            if (do_pop)  rptr <= (rptr == LAST_PTR) ? '0 : rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end
endmodule

module axi_slice_isolate #(
    parameter int unsigned AXI_ADDR_WIDTH  = 32,
    parameter int unsigned AXI_DATA_WIDTH  = 64,
    parameter int unsigned AXI_USER_WIDTH  = 6,
    parameter int unsigned AXI_ID_WIDTH    = 4,
    parameter int unsigned SLICE_DEPTH     = 2,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    AXI_BUS.Slave                                axi_slave,
    AXI_BUS.Master                               axi_master,
    input  logic                                 isolate_i,
    output logic                                 isolated_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] wr_outstanding_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] rd_outstanding_o
);
    localparam int unsigned CW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned STRB = AXI_DATA_WIDTH / 8;
    localparam int unsigned AX_W = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 29 + AXI_USER_WIDTH;
    localparam int unsigned W_W  = AXI_DATA_WIDTH + STRB + 1 + AXI_USER_WIDTH;
    localparam int unsigned B_W  = AXI_ID_WIDTH + 2 + AXI_USER_WIDTH;
    localparam int unsigned R_W  = AXI_ID_WIDTH + AXI_DATA_WIDTH + 3 + AXI_USER_WIDTH;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {RUN, DRAIN, ISOLATED} state_t;

    state_t state;
    state_t state_next;

    logic [AX_W-1:0] aw_in, aw_out, ar_in, ar_out;
    logic [W_W-1:0]  w_in, w_out;
    logic [B_W-1:0]  b_in, b_out;
    logic [R_W-1:0]  r_in, r_out;
    logic aw_full, aw_empty, w_full, w_empty, b_full, b_empty;
    logic ar_full, ar_empty, r_full, r_empty;

    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;
    logic          accept_en;
    logic          aw_hs, b_hs, ar_hs, r_last_hs;
    logic          wr_inc, wr_dec, rd_inc, rd_dec;
    logic          drained;

    // Payload packing
    assign aw_in = {axi_slave.aw_id, axi_slave.aw_addr, axi_slave.aw_len, axi_slave.aw_size,
                    axi_slave.aw_burst, axi_slave.aw_lock, axi_slave.aw_cache, axi_slave.aw_prot,
                    axi_slave.aw_region, axi_slave.aw_qos, axi_slave.aw_user};
    assign {axi_master.aw_id, axi_master.aw_addr, axi_master.aw_len, axi_master.aw_size,
            axi_master.aw_burst, axi_master.aw_lock, axi_master.aw_cache, axi_master.aw_prot,
            axi_master.aw_region, axi_master.aw_qos, axi_master.aw_user} = aw_out;

    assign ar_in = {axi_slave.ar_id, axi_slave.ar_addr, axi_slave.ar_len, axi_slave.ar_size,
                    axi_slave.ar_burst, axi_slave.ar_lock, axi_slave.ar_cache, axi_slave.ar_prot,
                    axi_slave.ar_region, axi_slave.ar_qos, axi_slave.ar_user};
    assign {axi_master.ar_id, axi_master.ar_addr, axi_master.ar_len, axi_master.ar_size,
            axi_master.ar_burst, axi_master.ar_lock, axi_master.ar_cache, axi_master.ar_prot,
            axi_master.ar_region, axi_master.ar_qos, axi_master.ar_user} = ar_out;

    assign w_in = {axi_slave.w_data, axi_slave.w_strb, axi_slave.w_last, axi_slave.w_user};
    assign {axi_master.w_data, axi_master.w_strb, axi_master.w_last, axi_master.w_user} = w_out;

    assign b_in = {axi_master.b_id, axi_master.b_resp, axi_master.b_user};
    assign {axi_slave.b_id, axi_slave.b_resp, axi_slave.b_user} = b_out;

    assign r_in = {axi_master.r_id, axi_master.r_data, axi_master.r_resp, axi_master.r_last,
                   axi_master.r_user};
    assign {axi_slave.r_id, axi_slave.r_data, axi_slave.r_resp, axi_slave.r_last,
            axi_slave.r_user} = r_out;

    // Readies derive only from registered state, so no valid-to-ready path exists
    assign accept_en           = (state == RUN);
    assign axi_slave.aw_ready  = !rst_i && !aw_full && accept_en && (wr_cnt != MAX_CNT);
    assign axi_slave.ar_ready  = !rst_i && !ar_full && accept_en && (rd_cnt != MAX_CNT);
    assign axi_slave.w_ready   = !rst_i && !w_full;
    assign axi_master.b_ready  = !rst_i && !b_full;
    assign axi_master.r_ready  = !rst_i && !r_full;

    assign axi_master.aw_valid = !aw_empty;
    assign axi_master.ar_valid = !ar_empty;
    assign axi_master.w_valid  = !w_empty;
    assign axi_slave.b_valid   = !b_empty;
    assign axi_slave.r_valid   = !r_empty;

    axi_slice_isolate_fifo #(.WIDTH(AX_W), .DEPTH(SLICE_DEPTH)) aw_fifo (
        .clk(clk_i), .rst(rst_i),
        .push(axi_slave.aw_valid && axi_slave.aw_ready), .din(aw_in),
        .pop(axi_master.aw_valid && axi_master.aw_ready), .dout(aw_out),
        .full(aw_full), .empty(aw_empty)
    );

    axi_slice_isolate_fifo #(.WIDTH(W_W), .DEPTH(SLICE_DEPTH)) w_fifo (
        .clk(clk_i), .rst(rst_i),
        .push(axi_slave.w_valid && axi_slave.w_ready), .din(w_in),
        .pop(axi_master.w_valid && axi_master.w_ready), .dout(w_out),
        .full(w_full), .empty(w_empty)
    );

    axi_slice_isolate_fifo #(.WIDTH(AX_W), .DEPTH(SLICE_DEPTH)) ar_fifo (
        .clk(clk_i), .rst(rst_i),
        .push(axi_slave.ar_valid && axi_slave.ar_ready), .din(ar_in),
        .pop(axi_master.ar_valid && axi_master.ar_ready), .dout(ar_out),
        .full(ar_full), .empty(ar_empty)
    );

    axi_slice_isolate_fifo #(.WIDTH(B_W), .DEPTH(SLICE_DEPTH)) b_fifo (
        .clk(clk_i), .rst(rst_i),
        .push(axi_master.b_valid && axi_master.b_ready), .din(b_in),
        .pop(axi_slave.b_valid && axi_slave.b_ready), .dout(b_out),
        .full(b_full), .empty(b_empty)
    );

    axi_slice_isolate_fifo #(.WIDTH(R_W), .DEPTH(SLICE_DEPTH)) r_fifo (
        .clk(clk_i), .rst(rst_i),
        .push(axi_master.r_valid && axi_master.r_ready), .din(r_in),
        .pop(axi_slave.r_valid && axi_slave.r_ready), .dout(r_out),
        .full(r_full), .empty(r_empty)
    );

    assign aw_hs     = axi_slave.aw_valid && axi_slave.aw_ready;
    assign b_hs      = axi_slave.b_valid && axi_slave.b_ready;
    assign ar_hs     = axi_slave.ar_valid && axi_slave.ar_ready;
    assign r_last_hs = axi_slave.r_valid && axi_slave.r_ready && axi_slave.r_last;

    // Responses arriving with nothing outstanding pass through without touching the count
    assign wr_inc = aw_hs;
    assign wr_dec = b_hs && (wr_cnt != '0);
    assign rd_inc = ar_hs;
    assign rd_dec = r_last_hs && (rd_cnt != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (wr_inc && !wr_dec)      wr_cnt <= wr_cnt + 1'b1;
            else if (!wr_inc && wr_dec) wr_cnt <= wr_cnt - 1'b1;
            if (rd_inc && !rd_dec)      rd_cnt <= rd_cnt + 1'b1;
            else if (!rd_inc && rd_dec) rd_cnt <= rd_cnt - 1'b1;
        end
    end

    assign wr_outstanding_o = wr_cnt;
    assign rd_outstanding_o = rd_cnt;

    assign drained = (wr_cnt == '0) && (rd_cnt == '0) && aw_empty && w_empty && ar_empty
                     && b_empty && r_empty;

    always_comb begin
        state_next = state;
        case (state)
            RUN:      if (isolate_i) state_next = DRAIN;
            DRAIN: begin
                if (!isolate_i)   state_next = RUN;
                else if (drained) state_next = ISOLATED;
            end
            ISOLATED: if (!isolate_i) state_next = RUN;
            default:  state_next = RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= RUN;
            isolated_o <= 1'b0;
        end else begin
            state      <= state_next;
            isolated_o <= (state_next == ISOLATED);
        end
    end
endmodule

// File: doc/axi_slice_isolate.md
AXI_SLICE_ISOLATE -- requirements
Module: axi_slice_isolate

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, meaning address width of both ports.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 64, meaning data width; strobe width is AXI_DATA_WIDTH/8.
REQ-003 SHALL have parameter AXI_USER_WIDTH, default 6, meaning user width on all channels.
REQ-004 SHALL have parameter AXI_ID_WIDTH, default 4, meaning ID width, identical on both ports.
REQ-005 SHALL have parameter SLICE_DEPTH, default 2, meaning per-channel buffer depth, legal range 1..8.
REQ-006 SHALL have parameter MAX_OUTSTANDING, default 8, meaning per-direction transaction limit, legal range 1..255.
REQ-007 SHALL have port clk_i, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst_i, input, 1 bit, meaning asynchronous, active-high reset.
REQ-009 SHALL have port axi_slave, AXI_BUS.Slave, meaning upstream port driven by a master.
REQ-010 SHALL have port axi_master, AXI_BUS.Master, meaning downstream port driving a slave.
REQ-011 SHALL have port isolate_i, input, 1 bit, meaning request to stop accepting new AW/AR transactions.
REQ-012 SHALL have port isolated_o, output, 1 bit, meaning isolation is complete and no transactions are outstanding.
REQ-013 SHALL have port wr_outstanding_o, output, $clog2(MAX_OUTSTANDING+1) bits, meaning accepted writes without a B response.
REQ-014 SHALL have port rd_outstanding_o, output, $clog2(MAX_OUTSTANDING+1) bits, meaning accepted reads without a final R beat.

Function
REQ-015 SHALL buffer each of the AW, W, AR (slave to master) and B, R (master to slave) channels in an independent FIFO of SLICE_DEPTH entries carrying all payload fields.
REQ-016 SHALL drive a downstream valid 1 cycle after the upstream handshake, with no combinational path from any valid to any ready.
REQ-017 SHALL sustain 1 beat per cycle per channel when SLICE_DEPTH >= 2, and 1 beat per 2 cycles when SLICE_DEPTH = 1.
REQ-018 SHALL drive each upstream ready as "FIFO not full", gated as defined in REQ-021 and REQ-022, and each downstream valid as "FIFO not empty".
REQ-019 SHALL preserve beat order per channel, and SHALL neither drop nor duplicate beats.
REQ-020 SHALL update the outstanding counters as follows: wr +1 on a slave-side AW handshake, wr -1 on a slave-side B handshake, rd +1 on a slave-side AR handshake, rd -1 on a slave-side R handshake with last=1; an increment and a decrement in the same cycle leave the count unchanged.
REQ-021 SHALL force axi_slave aw_ready low while the wr count equals MAX_OUTSTANDING, and axi_slave ar_ready low while the rd count equals MAX_OUTSTANDING; counters never exceed MAX_OUTSTANDING and never underflow.
REQ-022 SHALL implement a state machine with states RUN, DRAIN and ISOLATED:
  - RUN: normal operation.
  - RUN->DRAIN: when isolate_i=1.
  - DRAIN: axi_slave aw_ready and ar_ready held low; W, B and R channels unaffected.
  - DRAIN->ISOLATED: when both counters are 0 and all five FIFOs are empty.
  - DRAIN->RUN or ISOLATED->RUN: when isolate_i=0.
  - ISOLATED: aw_ready and ar_ready held low.
REQ-023 SHALL assert isolated_o registered, exactly while the state is ISOLATED.
REQ-024 SHALL leave a handshake already in progress unaffected when isolate_i rises in the same cycle as an AW/AR handshake; that transaction is counted and drained.
REQ-025 SHALL treat an unexpected B or R response with its counter at 0 as a pass-through, with the counter held at 0.
REQ-026 SHALL drive the counter outputs directly from the registered counters.

Reset
REQ-027 SHALL, on rst_i=1, asynchronously empty all FIFOs, clear both counters to 0, enter RUN, and drive isolated_o=0 and all axi_master/axi_slave valids to 0.
REQ-028 SHALL discard buffered beats on a reset mid-burst, with no beat emitted after reset release until a new upstream handshake occurs.
REQ-029 SHALL drive readies low during reset; readies become 1 (FIFOs empty) in the first cycle after rst_i deasserts.

Verification
REQ-030 SHALL cover streaming: 16-beat W burst with continuous valid and downstream ready=1, SLICE_DEPTH=2 -> 16 beats in 16 consecutive cycles, first beat 1 cycle after input, data in order.
REQ-031 SHALL cover backpressure: downstream ready=0 with SLICE_DEPTH=2 -> upstream ready falls after 2 accepted beats; on ready=1, both beats emerge in order with no loss.
REQ-032 SHALL cover limit: MAX_OUTSTANDING=4, 5 ARs issued with no R returned -> 4 accepted, ar_ready=0, rd_outstanding_o=4; one R with last=1 -> 5th AR accepted.
REQ-033 SHALL cover isolation: 2 writes outstanding, isolate_i=1 -> aw_ready=0 next cycle, isolated_o=0; after both B responses and the FIFOs drain -> isolated_o=1; isolate_i=0 -> isolated_o=0 and aw_ready=1.
REQ-034 SHALL cover simultaneous events: AW and B handshakes in the same cycle at wr=3 -> wr_outstanding_o stays 3.
REQ-035 SHALL cover reset: rst_i pulsed mid R burst with 2 beats buffered -> all valids 0 immediately, counters 0, no stale R beat after release.
